fmsg_rx: RTL and testbench

Serial front end for the fmsg path. It receives 8N1 asynchronous serial frames on a single line and assembles each one into an 8-bit fmsg byte, LSB first. Each byte is held in a one-deep output register behind a valid/ready handshake. The fmsg field decoder downstream consumes `fmsg` directly: TYPE is [7:6], DEST is [5:4], PAYLOAD is [3:0]. Framing errors and overruns are reported as single-cycle pulses.

---
 rtl/fmsg_rx.sv | 129 ++++++++++++
 tb/tb_fmsg_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fmsg_rx.sv
// fmsg_rx: 8N1 serial receiver feeding the fmsg field decoder.
// Mid-bit sampling, one-deep output register with valid/ready, and registered error pulses.
module fmsg_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] fmsg,
   output logic       fmsg_valid,
   input  logic       fmsg_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    fmsg_q, fmsg_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;
   logic          rxMeta_q, rxS_q;

   // Synchronizer flops reset high so a reset never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxMeta_q <= 1'b1;
         rxS_q    <= 1'b1;
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         fmsg_q   <= '0;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         rxMeta_q <= rx;
         rxS_q    <= rxMeta_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         fmsg_q   <= fmsg_d;
         valid_q  <= valid_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      fmsg_d  = fmsg_q;
      valid_d = valid_q & ~fmsg_ready;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxS_q) state_d = START;
         end
         START: begin
            if (cnt_q == HalfLast) begin
               cnt_d = '0;
               idx_d = '0;
               state_d = rxS_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == BitLast) begin
               cnt_d = '0;
               shift_d[idx_q] = rxS_q;
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         STOP: begin
            if (cnt_q == BitLast) begin
               cnt_d = '0;
               // A good byte may load in the same cycle the held byte drains.
               if (rxS_q) begin
                  state_d = IDLE;
                  if (!valid_q || fmsg_ready) begin
                     fmsg_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     ovr_d = 1'b1;
                  end
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            cnt_d = '0;
            if (rxS_q) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign fmsg       = fmsg_q;
   assign fmsg_valid = valid_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_fmsg_rx.sv
// Directed bench for fmsg_rx at CLKS_PER_BIT=16: stimulus pushes expected bytes,
// a negedge monitor pops and compares on every transfer and tracks error pulses.
module tb_fmsg_rx;

   localparam int Cpb = 16;

   logic       clock;
   logic       rstN;
   logic       rxLine;
   logic [7:0] fmsgOut;
   logic       fmsgValid;
   logic       fmsgReady;
   logic       frameErr;
   logic       overrunOut;

   int checks = 0;
   int errors = 0;
   int frameErrCycles = 0;
   int overrunCycles = 0;
   logic [7:0] expQ[$];
   logic       prevHeld = 1'b0;
   logic [7:0] prevData = 8'h00;

   fmsg_rx #(.CLKS_PER_BIT(Cpb)) dut (
      .clk        (clock),
      .rst_n      (rstN),
      .rx         (rxLine),
      .fmsg       (fmsgOut),
      .fmsg_valid (fmsgValid),
      .fmsg_ready (fmsgReady),
      .frame_err  (frameErr),
      .overrun    (overrunOut)
   );

   // Free-running 10 ns clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drives one 8N1 frame LSB first; stopLow > 0 holds the stop bit low that many cycles.
   task automatic applyStimulus(input logic [7:0] data, input int stopLow);
      rxLine = 1'b0;
      repeat (Cpb) tick();
      for (int i = 0; i < 8; i++) begin
         rxLine = data[i];
         repeat (Cpb) tick();
      end
      if (stopLow > 0) begin
         rxLine = 1'b0;
         repeat (stopLow) tick();
      end
      rxLine = 1'b1;
      repeat (Cpb) tick();
   endtask

   // Scoreboard monitor: compares every transfer, checks held data stays put.
   always @(negedge clock) begin
      if (!rstN) begin
         prevHeld = 1'b0;
      end else begin
         if (frameErr)   frameErrCycles++;
         if (overrunOut) overrunCycles++;
         if (prevHeld) begin
            checkOutput("hold_valid", 32'(fmsgValid), 32'd1);
            checkOutput("hold_data", 32'(fmsgOut), 32'(prevData));
         end
         if (fmsgValid && fmsgReady) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_byte: got %0h, expected no byte", fmsgOut);
            end else begin
               logic [7:0] expByte;
               expByte = expQ.pop_front();
               checkOutput("rx_byte", 32'(fmsgOut), 32'(expByte));
               if (expByte == 8'hA5) begin
                  checkOutput("field_type", 32'(fmsgOut[7:6]), 32'd2);
                  checkOutput("field_dest", 32'(fmsgOut[5:4]), 32'd2);
                  checkOutput("field_payload", 32'(fmsgOut[3:0]), 32'd5);
               end
            end
         end
         prevHeld = fmsgValid && !fmsgReady;
         prevData = fmsgOut;
      end
   end

   // Hard stop if the stimulus ever stalls.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstN      = 1'b0;
      rxLine    = 1'b1;
      fmsgReady = 1'b1;
      #3;
      checkOutput("reset_fmsg", 32'(fmsgOut), 32'h00);
      checkOutput("reset_valid", 32'(fmsgValid), 32'd0);
      checkOutput("reset_frame_err", 32'(frameErr), 32'd0);
      checkOutput("reset_overrun", 32'(overrunOut), 32'd0);
      repeat (3) tick();
      rstN = 1'b1;
      repeat (10) tick();

      $display("[TB] basic receive 0xA5");
      expQ.push_back(8'hA5);
      applyStimulus(8'hA5, 0);
      repeat (20) tick();

      $display("[TB] glitch then 0x3C");
      rxLine = 1'b0;
      repeat (3) tick();
      rxLine = 1'b1;
      repeat (40) tick();
      expQ.push_back(8'h3C);
      applyStimulus(8'h3C, 0);
      repeat (20) tick();

      $display("[TB] framing error on 0x81, then 0x42");
      applyStimulus(8'h81, 40);
      repeat (20) tick();
      checkOutput("frame_err_count", 32'(frameErrCycles), 32'd1);
      expQ.push_back(8'h42);
      applyStimulus(8'h42, 0);
      repeat (20) tick();

      $display("[TB] overrun 0x11 then 0x22");
      fmsgReady = 1'b0;
      expQ.push_back(8'h11);
      applyStimulus(8'h11, 0);
      applyStimulus(8'h22, 0);
      repeat (10) tick();
      checkOutput("overrun_count", 32'(overrunCycles), 32'd1);
      checkOutput("overrun_held", 32'(fmsgOut), 32'h11);
      fmsgReady = 1'b1;
      tick();
      fmsgReady = 1'b0;
      checkOutput("valid_after_transfer", 32'(fmsgValid), 32'd0);
      repeat (10) tick();

      $display("[TB] drain and load in the same cycle");
      expQ.push_back(8'h11);
      expQ.push_back(8'h22);
      fork
         begin
            applyStimulus(8'h11, 0);
            applyStimulus(8'h22, 0);
         end
         begin
            // Second stop sample is evaluated in the cycle ending 315 edges after the first start bit.
            repeat (314) tick();
            fmsgReady = 1'b1;
            tick();
            fmsgReady = 1'b0;
            checkOutput("drain_valid", 32'(fmsgValid), 32'd1);
            checkOutput("drain_data", 32'(fmsgOut), 32'h22);
         end
      join
      repeat (10) tick();
      checkOutput("drain_no_overrun", 32'(overrunCycles), 32'd1);

      $display("[TB] reset during data bit 4 of 0xF0");
      fork
         applyStimulus(8'hF0, 0);
         begin
            repeat (Cpb * 5 + 8) tick();
            rstN = 1'b0;
            #1;
            checkOutput("midreset_fmsg", 32'(fmsgOut), 32'h00);
            checkOutput("midreset_valid", 32'(fmsgValid), 32'd0);
            checkOutput("midreset_frame_err", 32'(frameErr), 32'd0);
            checkOutput("midreset_overrun", 32'(overrunOut), 32'd0);
            expQ.delete();
            repeat (10) tick();
            rstN = 1'b1;
         end
      join
      fmsgReady = 1'b1;
      repeat (40) tick();
      checkOutput("post_reset_idle", 32'(fmsgValid), 32'd0);
      expQ.push_back(8'h5A);
      applyStimulus(8'h5A, 0);
      repeat (20) tick();

      checkOutput("frame_err_total", 32'(frameErrCycles), 32'd1);
      checkOutput("overrun_total", 32'(overrunCycles), 32'd1);
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
